// File: rtl/serial_adder_if.sv
// Valid/ready operand and result channels of the bit-serial adder.
// The master drives operands and accepts results; the adder is the slave.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, sum, cout, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, sum, cout, busy
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: two cascaded half-adder cells and a carry flop add two
// WIDTH-bit operands LSB first, one bit per clock, behind valid/ready handshakes.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("serial_adder: WIDTH must be in 1..32");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_b;
    logic [WIDTH-1:0] sum_q;
    logic             carry;
    logic             cout_q;
    logic [CW-1:0]    count;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;

    logic             p;
    logic             g1;
    logic             s;
    logic             g2;
    logic             carry_next;
    logic [WIDTH-1:0] sum_next;

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        p          = shift_a[0] ^ shift_b[0];
        g1         = shift_a[0] & shift_b[0];
        s          = p ^ carry;
        g2         = p & carry;
        carry_next = g1 | g2;
        sum_next   = sum_q >> 1;
        sum_next[WIDTH-1] = s;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            shift_a     <= '0;
            shift_b     <= '0;
            sum_q       <= '0;
            carry       <= 1'b0;
            cout_q      <= 1'b0;
            count       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    // in_ready_q gates the accept so the first cycle out of reset takes nothing.
                    if (in_ready_q && bus.in_valid) begin
                        shift_a    <= bus.a;
                        shift_b    <= bus.b;
                        carry      <= 1'b0;
                        count      <= '0;
                        sum_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    carry   <= carry_next;
                    sum_q   <= sum_next;
                    shift_a <= shift_a >> 1;
                    shift_b <= shift_b >> 1;
                    count   <= count + CW'(1);
                    if (count == LAST) begin
                        cout_q      <= carry_next;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 handshake, stall, ignore and reset
// cases, plus an exhaustive WIDTH=3 sweep with hand-derived expectations.
module tb_serial_adder;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(3)) if3 ();

    serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_adder #(.WIDTH(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 transaction; stall holds out_ready low for that many cycles after out_valid.
    task automatic txn8(input logic [7:0] a, input logic [7:0] b, input int stall,
                        input logic [7:0] exp_sum, input logic exp_cout);
        int k;
        int lat;
        k = 0;
        while (if8.in_ready !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        check("in_ready_before_load", 32'(if8.in_ready), 32'd1);
        if8.a         = a;
        if8.b         = b;
        if8.in_valid  = 1'b1;
        if8.out_ready = (stall == 0);
        tick();
        if8.in_valid = 1'b0;
        check("busy_after_accept", 32'(if8.busy), 32'd1);
        check("in_ready_in_run", 32'(if8.in_ready), 32'd0);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (if8.out_valid !== 1'b1 && lat < 40);
        check("latency8", 32'(lat), 32'd8);
        check("sum8", 32'(if8.sum), 32'(exp_sum));
        check("cout8", 32'(if8.cout), 32'(exp_cout));
        check("busy_in_done", 32'(if8.busy), 32'd0);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("stall_out_valid", 32'(if8.out_valid), 32'd1);
            check("stall_sum", 32'(if8.sum), 32'(exp_sum));
            check("stall_cout", 32'(if8.cout), 32'(exp_cout));
            check("stall_in_ready", 32'(if8.in_ready), 32'd0);
        end
        if8.out_ready = 1'b1;
        tick();
        check("out_valid_cleared", 32'(if8.out_valid), 32'd0);
        check("in_ready_after_handshake", 32'(if8.in_ready), 32'd1);
        check("sum_held_in_idle", 32'(if8.sum), 32'(exp_sum));
    endtask

    initial begin
        int lat;
        int k;
        logic [3:0] exp3;

        n_checks     = 0;
        n_errors     = 0;
        rst          = 1'b1;
        if8.in_valid = 1'b0;
        if8.a        = '0;
        if8.b        = '0;
        if8.out_ready = 1'b0;
        if3.in_valid = 1'b0;
        if3.a        = '0;
        if3.b        = '0;
        if3.out_ready = 1'b1;

        #1;
        check("rst_sum", 32'(if8.sum), 32'd0);
        check("rst_cout", 32'(if8.cout), 32'd0);
        check("rst_out_valid", 32'(if8.out_valid), 32'd0);
        check("rst_busy", 32'(if8.busy), 32'd0);
        check("rst_in_ready", 32'(if8.in_ready), 32'd0);
        repeat (3) tick();
        check("in_ready_held_in_rst", 32'(if8.in_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("in_ready_after_rst", 32'(if8.in_ready), 32'd1);

        txn8(8'h00, 8'h00, 0, 8'h00, 1'b0);
        txn8(8'hFF, 8'h01, 0, 8'h00, 1'b1);
        txn8(8'hA5, 8'h5A, 0, 8'hFF, 1'b0);
        txn8(8'd200, 8'd100, 5, 8'h2C, 1'b1);

        // Operands offered during RUN must be ignored.
        if8.a         = 8'h01;
        if8.b         = 8'h02;
        if8.in_valid  = 1'b1;
        if8.out_ready = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        if8.a        = 8'h77;
        tick();
        tick();
        if8.a        = 8'h0F;
        if8.b        = 8'h0F;
        if8.in_valid = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        lat = 3;
        while (if8.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check("ignore_latency", 32'(lat), 32'd8);
        check("ignore_sum", 32'(if8.sum), 32'h03);
        check("ignore_cout", 32'(if8.cout), 32'd0);
        tick();
        check("ignore_out_valid_cleared", 32'(if8.out_valid), 32'd0);
        tick();
        tick();
        check("second_pair_not_taken", 32'(if8.busy), 32'd0);

        // Asynchronous reset at RUN count=4, after a transaction that left cout=1.
        txn8(8'hFF, 8'h01, 0, 8'h00, 1'b1);
        if8.a        = 8'hFF;
        if8.b        = 8'hFF;
        if8.in_valid = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        repeat (4) tick();
        check("pre_rst_busy", 32'(if8.busy), 32'd1);
        check("pre_rst_partial_sum", 32'(if8.sum != 8'h00), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", 32'(if8.out_valid), 32'd0);
        check("async_rst_sum", 32'(if8.sum), 32'd0);
        check("async_rst_cout", 32'(if8.cout), 32'd0);
        check("async_rst_busy", 32'(if8.busy), 32'd0);
        check("async_rst_in_ready", 32'(if8.in_ready), 32'd0);
        tick();
        rst = 1'b0;
        check("no_out_valid_after_rst", 32'(if8.out_valid), 32'd0);
        tick();
        check("in_ready_after_rst2", 32'(if8.in_ready), 32'd1);
        txn8(8'h80, 8'h80, 0, 8'h00, 1'b1);

        // Exhaustive WIDTH=3 sweep, back to back.
        for (int ai = 0; ai < 8; ai++) begin
            for (int bi = 0; bi < 8; bi++) begin
                k = 0;
                while (if3.in_ready !== 1'b1 && k < 20) begin
                    tick();
                    k++;
                end
                check("w3_in_ready", 32'(if3.in_ready), 32'd1);
                if3.a        = 3'(ai);
                if3.b        = 3'(bi);
                if3.in_valid = 1'b1;
                tick();
                if3.in_valid = 1'b0;
                lat = 0;
                do begin
                    tick();
                    lat++;
                end while (if3.out_valid !== 1'b1 && lat < 20);
                exp3 = 4'(ai + bi);
                check("w3_latency", 32'(lat), 32'd3);
                check("w3_result", 32'({if3.cout, if3.sum}), 32'(exp3));
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
